dut_cmd_responder: RTL and testbench

DUT_CMD_RESPONDER -- requirements
Module: dut_cmd_responder

---
 rtl/dut_cmd_responder.sv | 206 ++++++++++++++++++++
 tb/tb_dut_cmd_responder.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dut_cmd_responder.sv
// dut_cmd_responder
//   Command-driven responder around a 256x8 memory. A command is taken on the
//   IDLE cycle where DUT_ctr_en is high. It then runs DECODE -> EXEC -> DONE,
//   or DECODE -> CLEAR (256 cycles) -> DONE for command 0x04.
//
// Ports
//   CLK                 system clock
//   RESET               synchronous active-high reset
//   DUT_ctr_rst         synchronous active-high soft reset (DUT_dout held)
//   DUT_ctr_en          command strobe, honoured only in IDLE
//   DUT_ctr_cmd[7:0]    command code: 00 NOP, 01 WRITE, 02 READ, 04 CLEAR
//   DUT_ctr_in_process  busy flag, high outside IDLE
//   DUT_din[7:0]        write data
//   DUT_dout[7:0]       read data, held until the next READ or RESET
//   DUT_row_addr[7:0]   base address
//   DUT_col_addr[3:0]   offset high nibble
//   DUT_sub_addr[3:0]   offset low nibble
//   DUT_sram_mode       0 = direct, 1 = auto-increment pointer
//   DUT_tid_index[7:0]  ID-table index
//   DUT_tid_data[31:0]  ID-table word, registered (1-cycle latency)
//
// Build option
//   DUT_RESP_TID_EN  defined: ID table plus cmd/busy-error/bad-cmd counters.
//                    undefined: DUT_tid_data is constant 0, no counters.
//
// state  | meaning
// IDLE   | waiting for DUT_ctr_en
// DECODE | latched command being classified
// EXEC   | single memory access (WRITE/READ) or no-op
// CLEAR  | zeroing addresses 0..255, one per cycle
// DONE   | pointer update, return to IDLE

module dut_cmd_responder (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        DUT_ctr_rst,
  input  logic        DUT_ctr_en,
  input  logic [7:0]  DUT_ctr_cmd,
  output logic        DUT_ctr_in_process,
  input  logic [7:0]  DUT_din,
  output logic [7:0]  DUT_dout,
  input  logic [7:0]  DUT_row_addr,
  input  logic [3:0]  DUT_col_addr,
  input  logic [3:0]  DUT_sub_addr,
  input  logic        DUT_sram_mode,
  input  logic [7:0]  DUT_tid_index,
  output logic [31:0] DUT_tid_data
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_DONE   = 3'd3;
  localparam logic [2:0] S_CLEAR  = 3'd4;

  localparam logic [7:0] CMD_NOP   = 8'h00;
  localparam logic [7:0] CMD_WRITE = 8'h01;
  localparam logic [7:0] CMD_READ  = 8'h02;
  localparam logic [7:0] CMD_CLEAR = 8'h04;

  logic [2:0] state;
  logic [7:0] cmd_q;
  logic [7:0] din_q;
  logic [7:0] row_q;
  logic [7:0] off_q;
  logic       mode_q;
  logic [7:0] ptr;
  logic [7:0] clr_cnt;
  logic [7:0] mem [256];

  logic       any_rst;
  logic [7:0] eff_addr;
  logic       mem_we;
  logic [7:0] mem_waddr;
  logic [7:0] mem_wdata;

  assign any_rst            = RESET | DUT_ctr_rst;
  assign DUT_ctr_in_process = (state != S_IDLE);
  // Direct mode ignores the pointer entirely.
  assign eff_addr           = row_q + off_q + (mode_q ? ptr : 8'h00);

  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = eff_addr;
    mem_wdata = din_q;
    if (!any_rst) begin
      if (state == S_EXEC && cmd_q == CMD_WRITE) begin
        mem_we = 1'b1;
      end else if (state == S_CLEAR) begin
        // clr_cnt counts 255 -> 0, so its complement walks addresses 0 -> 255.
        mem_we    = 1'b1;
        mem_waddr = ~clr_cnt;
        mem_wdata = 8'h00;
      end
    end
  end

  // Memory has no reset: contents survive both resets and aborted commands.
  always_ff @(posedge CLK) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  always_ff @(posedge CLK) begin
    if (any_rst) begin
      state   <= S_IDLE;
      ptr     <= 8'h00;
      clr_cnt <= 8'h00;
      if (RESET) begin
        DUT_dout <= 8'h00;
      end
    end else begin
      case (state)
        S_IDLE: begin
          if (DUT_ctr_en) begin
            cmd_q  <= DUT_ctr_cmd;
            din_q  <= DUT_din;
            row_q  <= DUT_row_addr;
            off_q  <= {DUT_col_addr, DUT_sub_addr};
            mode_q <= DUT_sram_mode;
            state  <= S_DECODE;
          end
        end
        S_DECODE: begin
          if (cmd_q == CMD_CLEAR) begin
            clr_cnt <= 8'hFF;
            state   <= S_CLEAR;
          end else begin
            state <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (cmd_q == CMD_READ) begin
            DUT_dout <= mem[eff_addr];
          end
          state <= S_DONE;
        end
        S_CLEAR: begin
          if (clr_cnt == 8'h00) begin
            state <= S_DONE;
          end else begin
            clr_cnt <= clr_cnt - 8'd1;
          end
        end
        S_DONE: begin
          if (!mode_q) begin
            ptr <= 8'h00;
          end else if (cmd_q == CMD_WRITE || cmd_q == CMD_READ) begin
            ptr <= ptr + 8'd1;
          end
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef DUT_RESP_TID_EN
  logic [15:0] cmd_cnt;
  logic [15:0] busy_err_cnt;
  logic [7:0]  bad_cmd_cnt;
  logic        cmd_bad;

  assign cmd_bad = !(DUT_ctr_cmd == CMD_NOP || DUT_ctr_cmd == CMD_WRITE ||
                     DUT_ctr_cmd == CMD_READ || DUT_ctr_cmd == CMD_CLEAR);

  always_ff @(posedge CLK) begin
    if (any_rst) begin
      cmd_cnt      <= 16'h0000;
      busy_err_cnt <= 16'h0000;
      bad_cmd_cnt  <= 8'h00;
    end else if (DUT_ctr_en) begin
      if (state == S_IDLE) begin
        cmd_cnt <= cmd_cnt + 16'd1;
        if (cmd_bad && bad_cmd_cnt != 8'hFF) begin
          bad_cmd_cnt <= bad_cmd_cnt + 8'd1;
        end
      end else if (busy_err_cnt != 16'hFFFF) begin
        busy_err_cnt <= busy_err_cnt + 16'd1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (any_rst) begin
      DUT_tid_data <= 32'h0000_0000;
    end else begin
      case (DUT_tid_index)
        8'h00:   DUT_tid_data <= 32'h4B48_5553;
        8'h01:   DUT_tid_data <= 32'h0001_0000;
        8'h02:   DUT_tid_data <= {16'h0000, cmd_cnt};
        8'h03:   DUT_tid_data <= {16'h0000, busy_err_cnt};
        8'h04:   DUT_tid_data <= {24'h00_0000, bad_cmd_cnt};
        8'h05:   DUT_tid_data <= {24'h00_0000, ptr};
        default: DUT_tid_data <= 32'h0000_0000;
      endcase
    end
  end
`else
  logic [7:0] unused_tid_index;
  assign unused_tid_index = DUT_tid_index;
  assign DUT_tid_data     = 32'h0000_0000;
`endif

endmodule

// File: tb/tb_dut_cmd_responder.sv
// Randomized self-checking bench for dut_cmd_responder with a behavioural
// memory/counter model. Honours DUT_RESP_TID_EN the same way as the design.

module tb_dut_cmd_responder;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        DUT_ctr_rst = 1'b0;
  logic        DUT_ctr_en = 1'b0;
  logic [7:0]  DUT_ctr_cmd = 8'h00;
  logic        DUT_ctr_in_process;
  logic [7:0]  DUT_din = 8'h00;
  logic [7:0]  DUT_dout;
  logic [7:0]  DUT_row_addr = 8'h00;
  logic [3:0]  DUT_col_addr = 4'h0;
  logic [3:0]  DUT_sub_addr = 4'h0;
  logic        DUT_sram_mode = 1'b0;
  logic [7:0]  DUT_tid_index = 8'h00;
  logic [31:0] DUT_tid_data;

  int tests_run = 0;
  int tests_failed = 0;

  // reference model state
  logic [7:0] m_mem [256];
  int         m_ptr;
  int         m_cmd_cnt;
  int         m_busy_err;
  int         m_bad;
  logic [7:0] m_dout;

  dut_cmd_responder dut (
    .CLK                (CLK),
    .RESET              (RESET),
    .DUT_ctr_rst        (DUT_ctr_rst),
    .DUT_ctr_en         (DUT_ctr_en),
    .DUT_ctr_cmd        (DUT_ctr_cmd),
    .DUT_ctr_in_process (DUT_ctr_in_process),
    .DUT_din            (DUT_din),
    .DUT_dout           (DUT_dout),
    .DUT_row_addr       (DUT_row_addr),
    .DUT_col_addr       (DUT_col_addr),
    .DUT_sub_addr       (DUT_sub_addr),
    .DUT_sram_mode      (DUT_sram_mode),
    .DUT_tid_index      (DUT_tid_index),
    .DUT_tid_data       (DUT_tid_data)
  );

  always #5 CLK = ~CLK;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_tid(input logic [7:0] idx);
`ifdef DUT_RESP_TID_EN
    case (idx)
      8'h00:   return 32'h4B48_5553;
      8'h01:   return 32'h0001_0000;
      8'h02:   return 32'(m_cmd_cnt % 65536);
      8'h03:   return 32'(m_busy_err);
      8'h04:   return 32'(m_bad);
      8'h05:   return 32'(m_ptr);
      default: return 32'h0;
    endcase
`else
    return 32'(idx) & 32'h0;
`endif
  endfunction

  task automatic model_reset(input bit hard);
    m_ptr = 0; m_cmd_cnt = 0; m_busy_err = 0; m_bad = 0;
    if (hard) m_dout = 8'h00;
  endtask

  task automatic model_cmd(input logic [7:0] cmd, input logic [7:0] din, input logic [7:0] row,
                           input logic [3:0] col, input logic [3:0] sub, input bit mode);
    int addr;
    addr = (int'(row) + int'(col) * 16 + int'(sub) + (mode ? m_ptr : 0)) % 256;
    m_cmd_cnt++;
    case (cmd)
      8'h00: ;
      8'h01: m_mem[addr] = din;
      8'h02: m_dout = m_mem[addr];
      8'h04: for (int a = 0; a < 256; a++) m_mem[a] = 8'h00;
      default: if (m_bad < 255) m_bad++;
    endcase
    if (!mode) m_ptr = 0;
    else if (cmd == 8'h01 || cmd == 8'h02) m_ptr = (m_ptr + 1) % 256;
  endtask

  // Issues one command and follows it to IDLE. pulse_at > 0 raises
  // DUT_ctr_en for one cycle during that busy cycle.
  task automatic run_cmd(input string tag, input logic [7:0] cmd, input logic [7:0] din,
                         input logic [7:0] row, input logic [3:0] col, input logic [3:0] sub,
                         input bit mode, input int pulse_at);
    int cnt;
    int exp_busy;
    exp_busy = (cmd == 8'h04) ? 258 : 3;
    model_cmd(cmd, din, row, col, sub, mode);
    @(posedge CLK); #1;
    DUT_ctr_cmd = cmd; DUT_din = din; DUT_row_addr = row;
    DUT_col_addr = col; DUT_sub_addr = sub; DUT_sram_mode = mode;
    DUT_ctr_en = 1'b1;
    @(posedge CLK); #1;
    DUT_ctr_en = 1'b0;
    // scramble inputs: the command must run on the latched copies
    DUT_ctr_cmd = 8'(($urandom % 2 == 0) ? 8'h04 : 8'h01);
    DUT_din = 8'($urandom); DUT_row_addr = 8'($urandom);
    DUT_col_addr = 4'($urandom); DUT_sub_addr = 4'($urandom); DUT_sram_mode = 1'($urandom);
    cnt = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge CLK);
      if (!DUT_ctr_in_process) break;
      cnt++;
      if (cnt == 3 && cmd == 8'h02) check_val({tag, "_dout_done"}, 32'(DUT_dout), 32'(m_dout));
      DUT_ctr_en = (cnt == pulse_at);
    end
    DUT_ctr_en = 1'b0;
    DUT_ctr_cmd = 8'h00;
    if (pulse_at > 0 && pulse_at <= exp_busy && m_busy_err < 65535) m_busy_err++;
    check_val({tag, "_busy"}, 32'(cnt), 32'(exp_busy));
    check_val({tag, "_dout"}, 32'(DUT_dout), 32'(m_dout));
  endtask

  task automatic read_chk(input string tag, input logic [7:0] addr);
    run_cmd(tag, 8'h02, 8'h00, addr, 4'h0, 4'h0, 1'b0, 0);
  endtask

  task automatic check_tid(input string tag, input logic [7:0] idx);
    @(negedge CLK);
    DUT_tid_index = idx;
    @(negedge CLK);
    check_val(tag, DUT_tid_data, exp_tid(idx));
  endtask

  task automatic pulse_reset(input bit hard);
    @(posedge CLK); #1;
    if (hard) RESET = 1'b1; else DUT_ctr_rst = 1'b1;
    @(posedge CLK); #1;
    RESET = 1'b0; DUT_ctr_rst = 1'b0;
    model_reset(hard);
  endtask

  // CLEAR aborted by a reset raised during busy cycle 'at'.
  task automatic abort_clear(input string tag, input int at, input bit hard);
    int cnt;
    @(posedge CLK); #1;
    DUT_ctr_cmd = 8'h04; DUT_row_addr = 8'h00; DUT_col_addr = 4'h0;
    DUT_sub_addr = 4'h0; DUT_sram_mode = 1'b0;
    DUT_ctr_en = 1'b1;
    @(posedge CLK); #1;
    DUT_ctr_en = 1'b0;
    cnt = 0;
    for (int i = 0; i < at; i++) begin
      @(negedge CLK);
      if (DUT_ctr_in_process) cnt++;
    end
    check_val({tag, "_busy_before"}, 32'(cnt), 32'(at));
    if (hard) RESET = 1'b1; else DUT_ctr_rst = 1'b1;
    @(negedge CLK);
    RESET = 1'b0; DUT_ctr_rst = 1'b0;
    check_val({tag, "_idle_after"}, 32'(DUT_ctr_in_process), 32'h0);
    // addresses 0..at-3 were written before the abort edge
    for (int a = 0; a <= at - 3; a++) m_mem[a] = 8'h00;
    model_reset(hard);
    check_val({tag, "_dout"}, 32'(DUT_dout), 32'(m_dout));
  endtask

  initial begin
    logic [7:0] cmd;
    logic [7:0] sel;
    bit         mode;
    int         pulse;

    for (int a = 0; a < 256; a++) m_mem[a] = 8'h00;
    model_reset(1'b1);

    // reset state
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check_val("rst_busy", 32'(DUT_ctr_in_process), 32'h0);
    check_val("rst_dout", 32'(DUT_dout), 32'h0);
    check_val("rst_tid", DUT_tid_data, 32'h0);
    RESET = 1'b0;
    check_tid("tid_sig", 8'h00);
    check_tid("tid_ver", 8'h01);
    check_tid("tid_other", 8'h9C);

    // bring memory to a known state
    run_cmd("init_clear", 8'h04, 8'h00, 8'h00, 4'h0, 4'h0, 1'b0, 0);

    // write then read back at row+offset
    pulse_reset(1'b1);
    run_cmd("wr_a5", 8'h01, 8'hA5, 8'h10, 4'h2, 4'h3, 1'b0, 0);
    run_cmd("rd_a5", 8'h02, 8'h00, 8'h10, 4'h2, 4'h3, 1'b0, 0);
    check_val("rd_a5_value", 32'(DUT_dout), 32'hA5);

    // auto-increment wraps 0xFF -> 0x00
    pulse_reset(1'b0);
    run_cmd("inc_wr1", 8'h01, 8'h11, 8'hFF, 4'h0, 4'h0, 1'b1, 0);
    run_cmd("inc_wr2", 8'h01, 8'h22, 8'hFF, 4'h0, 4'h0, 1'b1, 0);
    check_tid("tid_ptr", 8'h05);
    check_val("tid_ptr_value", DUT_tid_data & 32'hFFFF_FFFD, 32'h0);
    read_chk("rd_ff", 8'hFF);
    check_val("rd_ff_value", 32'(DUT_dout), 32'h11);
    read_chk("rd_00", 8'h00);
    check_val("rd_00_value", 32'(DUT_dout), 32'h22);
    check_tid("tid_ptr_cleared", 8'h05);

    // strobe while busy is ignored and counted
    pulse_reset(1'b0);
    run_cmd("busy_pulse", 8'h01, 8'h3C, 8'h40, 4'h0, 4'h1, 1'b0, 2);
    check_tid("tid_busy_err", 8'h03);
    check_tid("tid_cmd_cnt", 8'h02);

    // unknown command
    pulse_reset(1'b0);
    run_cmd("bad_7f", 8'h7F, 8'hEE, 8'h10, 4'h2, 4'h3, 1'b0, 0);
    check_tid("tid_bad", 8'h04);
    read_chk("rd_after_bad", 8'h23);

    // fill every address, then CLEAR
    for (int a = 0; a < 256; a++)
      run_cmd("fill", 8'h01, 8'($urandom_range(1, 255)), 8'(a), 4'h0, 4'h0, 1'b0, 0);
    read_chk("rd_filled", 8'h80);
    run_cmd("clear", 8'h04, 8'h00, 8'h00, 4'h0, 4'h0, 1'b0, 0);
    read_chk("rd_clr_00", 8'h00);
    read_chk("rd_clr_55", 8'h55);
    read_chk("rd_clr_ff", 8'hFF);
    read_chk("rd_clr_rand", 8'($urandom));

    // soft reset 100 cycles into CLEAR
    run_cmd("pre_wr_c8", 8'h01, 8'h5C, 8'hC8, 4'h0, 4'h0, 1'b0, 0);
    run_cmd("pre_wr_0a", 8'h01, 8'h6D, 8'h0A, 4'h0, 4'h0, 1'b0, 0);
    run_cmd("pre_wr_61", 8'h01, 8'h7E, 8'h61, 4'h0, 4'h0, 1'b0, 0);
    run_cmd("pre_wr_96", 8'h01, 8'h8F, 8'h96, 4'h0, 4'h0, 1'b0, 0);
    read_chk("pre_rd_96", 8'h96);
    abort_clear("abort_soft", 100, 1'b0);
    read_chk("ab_rd_0a", 8'h0A);
    read_chk("ab_rd_61", 8'h61);
    read_chk("ab_rd_c8", 8'hC8);
    read_chk("ab_rd_96", 8'h96);
    check_tid("ab_tid_cnt", 8'h02);

    // hard reset mid-CLEAR
    run_cmd("pre_wr_f0", 8'h01, 8'h9A, 8'hF0, 4'h0, 4'h0, 1'b0, 0);
    abort_clear("abort_hard", 40, 1'b1);
    read_chk("abh_rd_f0", 8'hF0);

    // reset coinciding with the strobe drops the command
    @(posedge CLK); #1;
    DUT_ctr_cmd = 8'h01; DUT_din = 8'h42; DUT_row_addr = 8'h0A;
    DUT_col_addr = 4'h0; DUT_sub_addr = 4'h0; DUT_sram_mode = 1'b0;
    DUT_ctr_en = 1'b1; DUT_ctr_rst = 1'b1;
    @(posedge CLK); #1;
    DUT_ctr_en = 1'b0; DUT_ctr_rst = 1'b0;
    model_reset(1'b0);
    @(negedge CLK);
    check_val("coincide_idle", 32'(DUT_ctr_in_process), 32'h0);
    read_chk("coincide_rd", 8'h0A);

    // randomized traffic
    for (int n = 0; n < 80; n++) begin
      sel = 8'($urandom % 10);
      mode = 1'($urandom);
      if (sel < 3) cmd = 8'h01;
      else if (sel < 6) cmd = 8'h02;
      else if (sel == 6) cmd = 8'h00;
      else if (sel == 7) cmd = 8'(8 + $urandom % 248);
      else begin cmd = ($urandom % 2 == 0) ? 8'h01 : 8'h02; mode = 1'b1; end
      pulse = ($urandom % 8 == 0) ? 2 : 0;
      run_cmd("rand", cmd, 8'($urandom), 8'($urandom % 32), 4'($urandom % 2),
              4'($urandom), mode, pulse);
      if (n % 10 == 9) check_tid("rand_tid", 8'($urandom % 8));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
